risc_v_mem_wb: RTL and testbench
================================

# risc_v_mem_wb

Back end of the 5-stage RISC-V pipeline. It holds the EX/MEM pipeline register, data memory with byte/half/word access, and the MEM/WB pipeline register. It resolves conditional branches and drives the signals the front end consumes: PCSrc and PC_Branch to fetch, and RegWrite_WB, ALU_DATA_WB and RD_WB to the decode-stage register file. It also exports MEM-stage and WB-stage values for the forwarding unit.

## Interface
- DMEM_WORDS, 1024: data memory depth in 32-bit words (power of two).
- DMEM_AW, 10: word-address width, equal to log2(DMEM_WORDS).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears both pipeline registers.
- ALU_OUT_EX  in  32  ALU result, or effective address for loads and stores.
- PC_Branch_EX  in  32  branch target computed in EX.
- ZERO_EX, LT_EX, LTU_EX  in  1 each  ALU flags (equal, signed less-than, unsigned less-than).
- STORE_DATA_EX  in  32  forwarded rs2 value.
- RD_EX  in  5  destination register.
- FUNCT3_EX  in  3  access size or branch condition.
- MemRead_EX, MemWrite_EX, MemtoReg_EX, RegWrite_EX, Branch_EX  in  1 each  control signals.
- PCSrc  out  1  branch taken, to fetch.
- PC_Branch  out  32  target for fetch.
- ALU_OUT_MEM  out  32  EX/MEM ALU result, for forwarding.
- RD_MEM  out  5  EX/MEM destination register.
- RegWrite_MEM  out  1  EX/MEM register-write enable.
- RegWrite_WB  out  1  register-file write enable.
- ALU_DATA_WB  out  32  writeback data.
- RD_WB  out  5  writeback register.

## Operation
- EX/MEM register captures every *_EX input at each rising clk. It has no stall; a bubble is all-zero control.
- Branch resolution is combinational from the EX/MEM register:
  - PCSrc = Branch_MEM AND cond(FUNCT3_MEM).
  - 000 BEQ: Z. 001 BNE: !Z. 100 BLT: LT. 101 BGE: !LT. 110 BLTU: LTU. 111 BGEU: !LTU. 010/011: 0.
  - PC_Branch = PC_Branch_MEM unconditionally.
- Data memory: DMEM_WORDS×32. Word index = ALU_OUT_MEM[DMEM_AW+1:2]; higher address bits are ignored, so the address wraps.
- Read is combinational. Write is synchronous on rising clk when MemWrite_MEM=1, using byte enables:
  - SB (f3=x00): lane ALU_OUT_MEM[1:0], data STORE_DATA[7:0].
  - SH (x01): lanes {A[1],0} and {A[1],1}, data [15:0]; A[0] is ignored.
  - SW (x10): all lanes; A[1:0] are ignored.
  - f3=x11: no write.
- Load extraction in MEM uses the same lane selection:
  - LB/LH: sign-extended.
  - LBU (100) / LHU (101): zero-extended.
  - LW (010): full word.
  - Other encodings: 0.
- The memory array is not cleared by reset. It initialises to zero at time 0.
- MEM/WB register captures RegWrite_MEM, MemtoReg_MEM, RD_MEM, ALU_OUT_MEM and the extracted load data.
- Writeback: ALU_DATA_WB = MemtoReg_WB ? load_WB : alu_WB.
- RD_WB passes through. RegWrite_WB passes through, forced to 0 when RD_WB=0.

## Timing
- Reset (async) clears both registers. Outputs during reset:
  - PCSrc=0, PC_Branch=0.
  - ALU_OUT_MEM=0, RD_MEM=0, RegWrite_MEM=0.
  - RegWrite_WB=0, ALU_DATA_WB=0, RD_WB=0.
- Reset asserted mid-operation drops any in-flight store. No memory write occurs on an edge where reset is high.
- An instruction captured at edge N:
  - drives PCSrc, PC_Branch and the *_MEM outputs during cycle N→N+1;
  - commits its store at edge N+1;
  - drives the WB outputs during cycle N+1→N+2. Writeback latency is 2 edges.
- Store at edge N+1 followed by a load to the same word in the next slot: the load returns the new data. Memory bypass is not needed.
- MemRead and MemWrite both 1: the write happens and the read data is also captured (old contents).
- Branch_MEM=1 with MemWrite_MEM=0 never writes memory.

## Test plan
- Reset: assert reset asynchronously mid-cycle → all outputs 0 immediately. First edge after release with all-zero inputs → outputs remain 0.
- ALU writeback: ALU_OUT_EX=0x0000_1234, RD_EX=5, RegWrite_EX=1, MemtoReg_EX=0 → after 2 edges RegWrite_WB=1, RD_WB=5, ALU_DATA_WB=0x1234. Same with RD_EX=0 → RegWrite_WB=0.
- Store/load sizes:
  - SW 0x8081_82F3 to address 0x10.
  - LB from 0x10 → 0xFFFF_FFF3.
  - LBU from 0x13 → 0x0000_0080.
  - LH from 0x12 → 0xFFFF_8081.
  - LW from 0x10 → 0x8081_82F3.
- Partial store: after the SW above, SB 0x55 to 0x11, then LW 0x10 in the back-to-back slot → 0x8081_55F3.
- Branches: Branch_EX=1, PC_Branch_EX=0x40:
  - BEQ with Z=1 → PCSrc=1, PC_Branch=0x40, one cycle after the edge.
  - BNE with Z=1 → PCSrc=0.
  - BGEU with LTU=0 → PCSrc=1.
  - f3=010 → PCSrc=0.
- Address wrap: SW 0xDEAD_BEEF to address 4×DMEM_WORDS → LW from 0x0 returns 0xDEAD_BEEF.

Source files
------------

// File: rtl/risc_v_mem_wb.sv
// risc_v_mem_wb: EX/MEM register, byte-lane data memory, MEM/WB register.
// Ports: EX-stage inputs in; PCSrc/PC_Branch to fetch, *_MEM to forwarding, *_WB to regfile.
module risc_v_mem_wb #(
  parameter int DMEM_WORDS = 1024,
  parameter int DMEM_AW    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_OUT_EX,
  input  logic [31:0] PC_Branch_EX,
  input  logic        ZERO_EX,
  input  logic        LT_EX,
  input  logic        LTU_EX,
  input  logic [31:0] STORE_DATA_EX,
  input  logic [4:0]  RD_EX,
  input  logic [2:0]  FUNCT3_EX,
  input  logic        MemRead_EX,
  input  logic        MemWrite_EX,
  input  logic        MemtoReg_EX,
  input  logic        RegWrite_EX,
  input  logic        Branch_EX,
  output logic        PCSrc,
  output logic [31:0] PC_Branch,
  output logic [31:0] ALU_OUT_MEM,
  output logic [4:0]  RD_MEM,
  output logic        RegWrite_MEM,
  output logic        RegWrite_WB,
  output logic [31:0] ALU_DATA_WB,
  output logic [4:0]  RD_WB
);

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] pcb;
    logic        z;
    logic        lt;
    logic        ltu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        rw;
    logic        br;
  } ex_mem_t;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] ld;
  } mem_wb_t;

  ex_mem_t em_d, em_q;
  mem_wb_t wb_d, wb_q;

  logic [31:0] dmem_q [DMEM_WORDS] = '{default: '0};

  logic [DMEM_AW-1:0] widx;
  logic [1:0]         lane;
  logic [31:0]        rdata;
  logic [3:0]         be;
  logic [31:0]        wdata;
  logic [7:0]         rbyte;
  logic [15:0]        rhalf;
  logic [31:0]        ld_data;
  logic               cond;

  always_comb begin
    em_d     = '0;
    em_d.alu = ALU_OUT_EX;
    em_d.pcb = PC_Branch_EX;
    em_d.z   = ZERO_EX;
    em_d.lt  = LT_EX;
    em_d.ltu = LTU_EX;
    em_d.sd  = STORE_DATA_EX;
    em_d.rd  = RD_EX;
    em_d.f3  = FUNCT3_EX;
    em_d.mr  = MemRead_EX;
    em_d.mw  = MemWrite_EX;
    em_d.m2r = MemtoReg_EX;
    em_d.rw  = RegWrite_EX;
    em_d.br  = Branch_EX;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) em_q <= '0;
    else       em_q <= em_d;
  end

  always_comb begin
    cond = 1'b0;
    case (em_q.f3)
      3'b000:  cond = em_q.z;
      3'b001:  cond = !em_q.z;
      3'b100:  cond = em_q.lt;
      3'b101:  cond = !em_q.lt;
      3'b110:  cond = em_q.ltu;
      3'b111:  cond = !em_q.ltu;
      default: cond = 1'b0;
    endcase
  end

  assign PCSrc        = em_q.br & cond;
  assign PC_Branch    = em_q.pcb;
  assign ALU_OUT_MEM  = em_q.alu;
  assign RD_MEM       = em_q.rd;
  assign RegWrite_MEM = em_q.rw;

  // Upper address bits are dropped, so addresses wrap over the array.
  assign widx  = em_q.alu[DMEM_AW+1:2];
  assign lane  = em_q.alu[1:0];
  assign rdata = dmem_q[widx];

  always_comb begin
    be    = '0;
    wdata = '0;
    case (em_q.f3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{em_q.sd[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{em_q.sd[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wdata = em_q.sd;
      end
      default: be = '0;
    endcase
    if (!em_q.mw) be = '0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) dmem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_comb begin
    rbyte = '0;
    case (lane)
      2'd0: rbyte = rdata[7:0];
      2'd1: rbyte = rdata[15:8];
      2'd2: rbyte = rdata[23:16];
      2'd3: rbyte = rdata[31:24];
      default: rbyte = '0;
    endcase
    rhalf   = lane[1] ? rdata[31:16] : rdata[15:0];
    ld_data = '0;
    case (em_q.f3)
      3'b000:  ld_data = {{24{rbyte[7]}}, rbyte};
      3'b001:  ld_data = {{16{rhalf[15]}}, rhalf};
      3'b010:  ld_data = rdata;
      3'b100:  ld_data = {24'd0, rbyte};
      3'b101:  ld_data = {16'd0, rhalf};
      default: ld_data = '0;
    endcase
    if (!em_q.mr) ld_data = '0;
  end

  always_comb begin
    wb_d     = '0;
    wb_d.rw  = em_q.rw;
    wb_d.m2r = em_q.m2r;
    wb_d.rd  = em_q.rd;
    wb_d.alu = em_q.alu;
    wb_d.ld  = ld_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wb_q <= '0;
    else       wb_q <= wb_d;
  end

  assign ALU_DATA_WB = wb_q.m2r ? wb_q.ld : wb_q.alu;
  assign RD_WB       = wb_q.rd;
  assign RegWrite_WB = wb_q.rw & (wb_q.rd != 5'd0);

endmodule

// File: tb/tb_risc_v_mem_wb.sv
// tb_risc_v_mem_wb: directed + random stimulus against a byte-array model.
// Checks MEM outputs one edge and WB outputs two edges after issue.
module tb_risc_v_mem_wb;

  localparam int W = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALU_OUT_EX, PC_Branch_EX, STORE_DATA_EX;
  logic        ZERO_EX, LT_EX, LTU_EX;
  logic [4:0]  RD_EX;
  logic [2:0]  FUNCT3_EX;
  logic        MemRead_EX, MemWrite_EX, MemtoReg_EX, RegWrite_EX, Branch_EX;
  logic        PCSrc, RegWrite_MEM, RegWrite_WB;
  logic [31:0] PC_Branch, ALU_OUT_MEM, ALU_DATA_WB;
  logic [4:0]  RD_MEM, RD_WB;

  risc_v_mem_wb #(.DMEM_WORDS(W), .DMEM_AW(10)) dut (
    .clk(clk), .reset(reset),
    .ALU_OUT_EX(ALU_OUT_EX), .PC_Branch_EX(PC_Branch_EX),
    .ZERO_EX(ZERO_EX), .LT_EX(LT_EX), .LTU_EX(LTU_EX),
    .STORE_DATA_EX(STORE_DATA_EX), .RD_EX(RD_EX), .FUNCT3_EX(FUNCT3_EX),
    .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
    .MemtoReg_EX(MemtoReg_EX), .RegWrite_EX(RegWrite_EX),
    .Branch_EX(Branch_EX),
    .PCSrc(PCSrc), .PC_Branch(PC_Branch),
    .ALU_OUT_MEM(ALU_OUT_MEM), .RD_MEM(RD_MEM), .RegWrite_MEM(RegWrite_MEM),
    .RegWrite_WB(RegWrite_WB), .ALU_DATA_WB(ALU_DATA_WB), .RD_WB(RD_WB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, pcb, sd;
    logic        z, lt, ltu;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        mr, mw, m2r, rw, br;
  } ins_t;

  typedef struct {
    logic        pcsrc;
    logic [31:0] pcb, alu;
    logic [4:0]  rd;
    logic        rw;
    logic        rw_wb;
    logic [31:0] dwb;
    logic [4:0]  rdwb;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  logic [7:0] mb [4*W];
  bit   no_store = 0;
  exp_t pend_mem, pend_wb, bub_e;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  function automatic ins_t bub();
    ins_t i;
    i = '{alu: 0, pcb: 0, sd: 0, z: 0, lt: 0, ltu: 0, rd: 0, f3: 0,
          mr: 0, mw: 0, m2r: 0, rw: 0, br: 0};
    return i;
  endfunction

  function automatic ins_t ld(input logic [2:0] f3, input logic [31:0] a,
                              input logic [4:0] rd);
    ins_t i = bub();
    i.f3 = f3; i.alu = a; i.rd = rd;
    i.mr = 1; i.m2r = 1; i.rw = 1;
    return i;
  endfunction

  function automatic ins_t st(input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d);
    ins_t i = bub();
    i.f3 = f3; i.alu = a; i.sd = d; i.mw = 1;
    return i;
  endfunction

  function automatic ins_t brn(input logic [2:0] f3, input logic z,
                               input logic ltu);
    ins_t i = bub();
    i.f3 = f3; i.z = z; i.ltu = ltu; i.br = 1; i.pcb = 32'h40;
    return i;
  endfunction

  // Program-order model: a load sees every earlier store, and its own
  // store (if any) lands after it reads.
  task automatic model(input ins_t i, output exp_t e);
    int a, base, hb;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w, l;
    logic        c;
    a    = int'(i.alu) & (4*W - 1);
    base = a & ~3;
    hb   = base + (a[1] ? 2 : 0);
    b    = mb[a];
    h    = {mb[hb+1], mb[hb]};
    w    = {mb[base+3], mb[base+2], mb[base+1], mb[base]};
    case (i.f3)
      3'd0: c = i.z;
      3'd1: c = !i.z;
      3'd4: c = i.lt;
      3'd5: c = !i.lt;
      3'd6: c = i.ltu;
      3'd7: c = !i.ltu;
      default: c = 0;
    endcase
    l = 0;
    if (i.mr) begin
      case (i.f3)
        3'd0: l = {{24{b[7]}}, b};
        3'd1: l = {{16{h[15]}}, h};
        3'd2: l = w;
        3'd4: l = {24'd0, b};
        3'd5: l = {16'd0, h};
        default: l = 0;
      endcase
    end
    if (i.mw && !no_store) begin
      case (i.f3[1:0])
        2'd0: mb[a] = i.sd[7:0];
        2'd1: begin mb[hb] = i.sd[7:0]; mb[hb+1] = i.sd[15:8]; end
        2'd2: for (int k = 0; k < 4; k++) mb[base+k] = i.sd[8*k +: 8];
        default: ;
      endcase
    end
    e.pcsrc = i.br & c;
    e.pcb   = i.pcb;
    e.alu   = i.alu;
    e.rd    = i.rd;
    e.rw    = i.rw;
    e.rw_wb = i.rw && (i.rd != 0);
    e.dwb   = i.m2r ? l : i.alu;
    e.rdwb  = i.rd;
  endtask

  task automatic drive(input ins_t i);
    ALU_OUT_EX = i.alu; PC_Branch_EX = i.pcb; STORE_DATA_EX = i.sd;
    ZERO_EX = i.z; LT_EX = i.lt; LTU_EX = i.ltu;
    RD_EX = i.rd; FUNCT3_EX = i.f3;
    MemRead_EX = i.mr; MemWrite_EX = i.mw; MemtoReg_EX = i.m2r;
    RegWrite_EX = i.rw; Branch_EX = i.br;
  endtask

  task automatic check_all(input exp_t m, input exp_t w);
    chk("pcsrc", PCSrc, m.pcsrc);
    chk("pc_branch", PC_Branch, m.pcb);
    chk("alu_mem", ALU_OUT_MEM, m.alu);
    chk("rd_mem", RD_MEM, m.rd);
    chk("rw_mem", RegWrite_MEM, m.rw);
    chk("rw_wb", RegWrite_WB, w.rw_wb);
    chk("data_wb", ALU_DATA_WB, w.dwb);
    chk("rd_wb", RD_WB, w.rdwb);
  endtask

  task automatic cyc(input ins_t i);
    exp_t e;
    @(negedge clk);
    check_all(pend_mem, pend_wb);
    drive(i);
    model(i, e);
    pend_wb  = pend_mem;
    pend_mem = e;
    @(posedge clk);
  endtask

  initial begin
    ins_t i;
    for (int k = 0; k < 4*W; k++) mb[k] = 0;
    model(bub(), bub_e);
    pend_mem = bub_e;
    pend_wb  = bub_e;
    reset = 1;
    drive(bub());
    #2;
    check_all(bub_e, bub_e);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    cyc(bub());
    cyc(bub());

    i = bub(); i.alu = 32'h1234; i.rd = 5; i.rw = 1;
    cyc(i);
    i.rd = 0;
    cyc(i);
    #2;
    chk("alu_wb_rw", RegWrite_WB, 1'b1);
    chk("alu_wb_rd", RD_WB, 5'd5);
    chk("alu_wb_data", ALU_DATA_WB, 32'h1234);
    cyc(bub());
    #2;
    chk("alu_wb_rd0", RegWrite_WB, 1'b0);

    cyc(st(3'b010, 32'h10, 32'h8081_82F3));
    cyc(ld(3'b000, 32'h10, 5'd7));
    cyc(ld(3'b100, 32'h13, 5'd7));
    #2 chk("lb", ALU_DATA_WB, 32'hFFFF_FFF3);
    cyc(ld(3'b001, 32'h12, 5'd7));
    #2 chk("lbu", ALU_DATA_WB, 32'h0000_0080);
    cyc(ld(3'b010, 32'h10, 5'd7));
    #2 chk("lh", ALU_DATA_WB, 32'hFFFF_8081);
    cyc(st(3'b000, 32'h11, 32'h55));
    #2 chk("lw", ALU_DATA_WB, 32'h8081_82F3);
    cyc(ld(3'b010, 32'h10, 5'd9));
    cyc(bub());
    #2 chk("sb_lw", ALU_DATA_WB, 32'h8081_55F3);

    cyc(brn(3'b000, 1'b1, 1'b0));
    #2 chk("beq", PCSrc, 1'b1);
    chk("beq_pc", PC_Branch, 32'h40);
    cyc(brn(3'b001, 1'b1, 1'b0));
    #2 chk("bne", PCSrc, 1'b0);
    cyc(brn(3'b111, 1'b0, 1'b0));
    #2 chk("bgeu", PCSrc, 1'b1);
    cyc(brn(3'b010, 1'b1, 1'b1));
    #2 chk("f3_010", PCSrc, 1'b0);

    cyc(st(3'b010, 32'(4*W), 32'hDEAD_BEEF));
    cyc(ld(3'b010, 32'h0, 5'd8));
    cyc(bub());
    #2 chk("wrap", ALU_DATA_WB, 32'hDEAD_BEEF);

    no_store = 1;
    cyc(st(3'b010, 32'h20, 32'h1122_3344));
    no_store = 0;
    #2;
    reset = 1;
    drive(bub());
    #1;
    check_all(bub_e, bub_e);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    pend_mem = bub_e;
    pend_wb  = bub_e;
    cyc(ld(3'b010, 32'h20, 5'd3));
    cyc(bub());
    #2 chk("drop_store", ALU_DATA_WB, 32'h0);

    for (int n = 0; n < 400; n++) begin
      i.alu = $urandom & 32'hFFFF_F03F;
      i.pcb = $urandom;
      i.sd  = $urandom;
      i.z   = 1'($urandom);
      i.lt  = 1'($urandom);
      i.ltu = 1'($urandom);
      i.rd  = 5'($urandom);
      i.f3  = 3'($urandom);
      i.mr  = 1'($urandom);
      i.mw  = 1'($urandom);
      i.m2r = i.mr;
      i.rw  = 1'($urandom);
      i.br  = 1'($urandom);
      cyc(i);
    end
    cyc(bub());
    cyc(bub());
    cyc(bub());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
